// File: rtl/ecc_pkg.sv
// Shared types and constants for the elliptic-curve point sequencer:
// GFAU opcodes, register-file map, FSM states and the sequence ROM entry format.
package ecc_pkg;

  localparam int NUM_REGS = 8;
  localparam int ADD_LEN  = 9;
  localparam int DBL_LEN  = 12;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } gfau_op_e;

  localparam logic [2:0] REG_X1 = 3'd0;
  localparam logic [2:0] REG_Y1 = 3'd1;
  localparam logic [2:0] REG_X2 = 3'd2;
  localparam logic [2:0] REG_Y2 = 3'd3;
  localparam logic [2:0] REG_A  = 3'd4;
  localparam logic [2:0] REG_T0 = 3'd5;
  localparam logic [2:0] REG_T1 = 3'd6;
  localparam logic [2:0] REG_L  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_ACK   = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  typedef enum logic {
    SEQ_ADD = 1'b0,
    SEQ_DBL = 1'b1
  } seq_e;

  // Outcome of the special-case classification done in CHECK
  typedef enum logic [2:0] {
    CLS_ADD,
    CLS_DBL,
    CLS_INF,
    CLS_Q,
    CLS_P
  } cls_e;

  typedef struct packed {
    gfau_op_e   op;
    logic [2:0] src0;
    logic [2:0] src1;
    logic [2:0] dst;
    logic       last;
  } rom_entry_t;

  function automatic rom_entry_t mk_step(gfau_op_e op, logic [2:0] src0,
                                         logic [2:0] src1, logic [2:0] dst);
    rom_entry_t e;
    e.op   = op;
    e.src0 = src0;
    e.src1 = src1;
    e.dst  = dst;
    e.last = 1'b0;
    return e;
  endfunction

endpackage

// File: rtl/ecc_seq_rom.sv
// Field-op microprogram for affine point add and point double.
// Each entry names the GFAU op, two source registers and the destination register.
module ecc_seq_rom
  import ecc_pkg::*;
(
  input  seq_e       seq,
  input  logic [3:0] step,
  output rom_entry_t entry
);

  always_comb begin
    entry = mk_step(OP_ADD, REG_X1, REG_X1, REG_T0);
    if (seq == SEQ_ADD) begin
      case (step)
        4'd0: entry = mk_step(OP_SUB, REG_Y2, REG_Y1, REG_T0);
        4'd1: entry = mk_step(OP_SUB, REG_X2, REG_X1, REG_T1);
        4'd2: entry = mk_step(OP_DIV, REG_T0, REG_T1, REG_L);
        4'd3: entry = mk_step(OP_MUL, REG_L,  REG_L,  REG_T0);
        4'd4: entry = mk_step(OP_SUB, REG_T0, REG_X1, REG_T0);
        4'd5: entry = mk_step(OP_SUB, REG_T0, REG_X2, REG_X2);
        4'd6: entry = mk_step(OP_SUB, REG_X1, REG_X2, REG_T1);
        4'd7: entry = mk_step(OP_MUL, REG_L,  REG_T1, REG_T1);
        4'd8: entry = mk_step(OP_SUB, REG_T1, REG_Y1, REG_Y2);
        default: ;
      endcase
      entry.last = (step >= 4'(ADD_LEN - 1));
    end else begin
      case (step)
        4'd0:  entry = mk_step(OP_MUL, REG_X1, REG_X1, REG_T0);
        4'd1:  entry = mk_step(OP_ADD, REG_T0, REG_T0, REG_T1);
        4'd2:  entry = mk_step(OP_ADD, REG_T1, REG_T0, REG_T0);
        4'd3:  entry = mk_step(OP_ADD, REG_T0, REG_A,  REG_T0);
        4'd4:  entry = mk_step(OP_ADD, REG_Y1, REG_Y1, REG_T1);
        4'd5:  entry = mk_step(OP_DIV, REG_T0, REG_T1, REG_L);
        4'd6:  entry = mk_step(OP_MUL, REG_L,  REG_L,  REG_T0);
        4'd7:  entry = mk_step(OP_SUB, REG_T0, REG_X1, REG_T0);
        4'd8:  entry = mk_step(OP_SUB, REG_T0, REG_X1, REG_X2);
        4'd9:  entry = mk_step(OP_SUB, REG_X1, REG_X2, REG_T1);
        4'd10: entry = mk_step(OP_MUL, REG_L,  REG_T1, REG_T1);
        4'd11: entry = mk_step(OP_SUB, REG_T1, REG_Y1, REG_Y2);
        default: ;
      endcase
      entry.last = (step >= 4'(DBL_LEN - 1));
    end
  end

endmodule

// File: rtl/ecc_point_ctrl.sv
// Point add / double sequencer: resolves infinity and degenerate cases locally,
// otherwise walks the ROM microprogram issuing one field op at a time to the GFAU.
//
// state | meaning
// IDLE  | waiting for i_start; operands latched on accept
// CHECK | classify special cases, pick add or double sequence
// ISSUE | register operands/op for the current step
// WAIT  | hold operands until the GFAU reports done, capture result
// ACK   | one-cycle ack to the GFAU, advance or finish
// DONE  | one-cycle o_done pulse, result held
module ecc_point_ctrl
  import ecc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_prime,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_x1,
  input  logic [WIDTH-1:0] i_y1,
  input  logic             i_p_inf,
  input  logic [WIDTH-1:0] i_x2,
  input  logic [WIDTH-1:0] i_y2,
  input  logic             i_q_inf,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_x3,
  output logic [WIDTH-1:0] o_y3,
  output logic             o_r_inf,
  output logic [WIDTH-1:0] o_gfau_in0,
  output logic [WIDTH-1:0] o_gfau_in1,
  output logic [WIDTH-1:0] o_gfau_prime,
  output logic [1:0]       o_gfau_op,
  output logic             o_gfau_ack,
  input  logic [WIDTH-1:0] i_gfau_result,
  input  logic             i_gfau_done
);

  state_e           state;
  seq_e             seq;
  logic [3:0]       step;
  logic             mode;
  logic             p_inf;
  logic             q_inf;
  logic [WIDTH-1:0] rf [NUM_REGS];
  rom_entry_t       rom;
  cls_e             cls;

  ecc_seq_rom u_rom (
    .seq   (seq),
    .step  (step),
    .entry (rom)
  );

  assign o_x3 = rf[REG_X2];
  assign o_y3 = rf[REG_Y2];

  always_comb begin
    cls = CLS_DBL;
    if (!mode) begin
      if (p_inf)
        cls = CLS_Q;
      else if (q_inf)
        cls = CLS_P;
      else if (rf[REG_X1] == rf[REG_X2] && rf[REG_Y1] == rf[REG_Y2])
        cls = CLS_DBL;
      else if (rf[REG_X1] == rf[REG_X2])
        cls = CLS_INF;
      else
        cls = CLS_ADD;
    end else if (p_inf || rf[REG_Y1] == '0) begin
      cls = CLS_INF;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      seq          <= SEQ_ADD;
      step         <= '0;
      mode         <= 1'b0;
      p_inf        <= 1'b0;
      q_inf        <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_r_inf      <= 1'b0;
      o_gfau_in0   <= '0;
      o_gfau_in1   <= '0;
      o_gfau_prime <= '0;
      o_gfau_op    <= '0;
      o_gfau_ack   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            rf[REG_X1]   <= i_x1;
            rf[REG_Y1]   <= i_y1;
            rf[REG_X2]   <= i_x2;
            rf[REG_Y2]   <= i_y2;
            rf[REG_A]    <= i_a;
            rf[REG_T0]   <= '0;
            rf[REG_T1]   <= '0;
            rf[REG_L]    <= '0;
            o_gfau_prime <= i_prime;
            mode         <= i_mode;
            p_inf        <= i_p_inf;
            q_inf        <= i_q_inf;
            o_r_inf      <= 1'b0;
            step         <= '0;
            o_busy       <= 1'b1;
            state        <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          case (cls)
            CLS_ADD: seq <= SEQ_ADD;
            CLS_DBL: seq <= SEQ_DBL;
            CLS_Q:   o_r_inf <= q_inf;
            CLS_P: begin
              rf[REG_X2] <= rf[REG_X1];
              rf[REG_Y2] <= rf[REG_Y1];
            end
            CLS_INF: begin
              rf[REG_X2] <= '0;
              rf[REG_Y2] <= '0;
              o_r_inf    <= 1'b1;
            end
            default: ;
          endcase
          if (cls == CLS_ADD || cls == CLS_DBL) begin
            state <= ST_ISSUE;
          end else begin
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= ST_DONE;
          end
        end
        ST_ISSUE: begin
          o_gfau_in0 <= rf[rom.src0];
          o_gfau_in1 <= rf[rom.src1];
          o_gfau_op  <= rom.op;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_gfau_done) begin
            rf[rom.dst] <= i_gfau_result;
            o_gfau_ack  <= 1'b1;
            state       <= ST_ACK;
          end
        end
        ST_ACK: begin
          o_gfau_ack <= 1'b0;
          if (rom.last) begin
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= ST_DONE;
          end else begin
            step  <= step + 4'd1;
            state <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          o_done <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_point_ctrl.sv
// Bench for ecc_point_ctrl with a behavioural GFAU over p=17, curve y^2=x^3+2x+2,
// checked against plain affine point arithmetic.
module tb_ecc_point_ctrl;

  localparam int W = 32;
  localparam int P = 17;
  localparam int A = 2;
  localparam logic [23:0] DBL_OPS = 24'b10_00_00_00_00_11_10_01_01_01_10_01;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0;
  logic         p_inf = 1'b0, q_inf = 1'b0;
  logic         busy, done, r_inf, gfau_ack, gfau_done;
  logic [W-1:0] x3, y3, gfau_in0, gfau_in1, gfau_prime, gfau_result;
  logic [1:0]   gfau_op;

  always #5 clk = ~clk;

  ecc_point_ctrl #(.WIDTH(W)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_mode        (mode),
    .i_prime       (W'(P)),
    .i_a           (W'(A)),
    .i_x1          (x1),
    .i_y1          (y1),
    .i_p_inf       (p_inf),
    .i_x2          (x2),
    .i_y2          (y2),
    .i_q_inf       (q_inf),
    .o_busy        (busy),
    .o_done        (done),
    .o_x3          (x3),
    .o_y3          (y3),
    .o_r_inf       (r_inf),
    .o_gfau_in0    (gfau_in0),
    .o_gfau_in1    (gfau_in1),
    .o_gfau_prime  (gfau_prime),
    .o_gfau_op     (gfau_op),
    .o_gfau_ack    (gfau_ack),
    .i_gfau_result (gfau_result),
    .i_gfau_done   (gfau_done)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Modular arithmetic helpers shared by the GFAU model and the point reference
  function automatic int md(int v);
    return ((v % P) + P) % P;
  endfunction

  function automatic int inv(int v);
    for (int i = 1; i < P; i++) if (md(v * i) == 1) return i;
    return 0;
  endfunction

  function automatic logic [W-1:0] gfau_calc(logic [W-1:0] a, logic [W-1:0] b,
                                              logic [1:0] op, logic [W-1:0] p);
    int ia, ib;
    if (p != W'(P)) return '0;
    ia = md(int'(a));
    ib = md(int'(b));
    case (op)
      2'b00:   return W'(md(ia + ib));
      2'b01:   return W'(md(ia - ib));
      2'b10:   return W'(md(ia * ib));
      default: return W'(md(ia * inv(ib)));
    endcase
  endfunction

  assign gfau_result = gfau_calc(gfau_in0, gfau_in1, gfau_op, gfau_prime);

  bit spurious_en = 1'b0;
  bit hold_done = 1'b0;
  int dly_min = 0;
  int dly_max = 0;

  // GFAU handshake: done after a random delay while the controller is busy,
  // cleared by ack; optional spurious done pulses while idle and during ack.
  initial begin
    int delay;
    delay = 0;
    gfau_done = 1'b0;
    forever begin
      @(negedge clk);
      if (gfau_ack) begin
        gfau_done = spurious_en && ($urandom_range(0, 1) == 1);
        delay = $urandom_range(dly_min, dly_max);
      end else if (!busy) begin
        gfau_done = spurious_en && ($urandom_range(0, 3) == 0);
        delay = $urandom_range(dly_min, dly_max);
      end else if (hold_done) begin
        gfau_done = 1'b0;
      end else if (delay == 0) begin
        gfau_done = 1'b1;
      end else begin
        delay--;
        gfau_done = 1'b0;
      end
    end
  end

  int ack_total = 0;
  logic [1:0] ack_ops[$];

  always @(negedge clk) begin
    if (gfau_ack) begin
      ack_total++;
      ack_ops.push_back(gfau_op);
    end
  end

  function automatic void ref_model(input bit m, input int ax, input int ay, input bit pi,
                                    input int bx, input int by, input bit qi,
                                    output int ex, output int ey, output bit einf,
                                    output int nops);
    int lam;
    bit dbl;
    ex = 0; ey = 0; einf = 1'b0; nops = 0; dbl = m;
    if (!m) begin
      if (pi) begin ex = bx; ey = by; einf = qi; return; end
      if (qi) begin ex = ax; ey = ay; return; end
      if (ax == bx) begin
        if (ay != by) begin einf = 1'b1; return; end
        dbl = 1'b1;
      end
    end
    if (dbl) begin
      if (pi || ay == 0) begin einf = 1'b1; return; end
      lam = md(md(3 * ax * ax + A) * inv(md(2 * ay)));
      ex = md(lam * lam - 2 * ax);
      nops = 12;
    end else begin
      lam = md(md(by - ay) * inv(md(bx - ax)));
      ex = md(lam * lam - ax - bx);
      nops = 9;
    end
    ey = md(lam * (ax - ex) - ay);
  endfunction

  task automatic op_check(input string tag, input bit m, input int ax, input int ay,
                          input bit pi, input int bx, input int by, input bit qi,
                          input bit noisy, input int exp_cyc, output logic [23:0] ops);
    int base, cyc, ex, ey, nops;
    bit einf;
    ref_model(m, ax, ay, pi, bx, by, qi, ex, ey, einf, nops);
    base = ack_total;
    @(negedge clk);
    mode = m; x1 = W'(ax); y1 = W'(ay); p_inf = pi;
    x2 = W'(bx); y2 = W'(by); q_inf = qi;
    start = 1'b1;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      #1;
      cyc++;
      if (done || cyc >= 3000) break;
      start = noisy;
      if (noisy) begin
        mode = $urandom_range(0, 1);
        x1 = $urandom_range(0, 16); y1 = $urandom_range(0, 16);
        x2 = $urandom_range(0, 16); y2 = $urandom_range(0, 16);
        p_inf = $urandom_range(0, 1); q_inf = $urandom_range(0, 1);
      end
    end
    start = 1'b0;
    chk({tag, "_timeout"}, 32'(cyc >= 3000), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_inf"}, 32'(r_inf), 32'(einf));
    if (!einf) begin
      chk({tag, "_x"}, x3, 32'(ex));
      chk({tag, "_y"}, y3, 32'(ey));
    end
    chk({tag, "_acks"}, 32'(ack_total - base), 32'(nops));
    if (exp_cyc >= 0) chk({tag, "_lat"}, 32'(cyc), 32'(exp_cyc));
    ops = '0;
    for (int i = base; i < ack_total && i < base + 12; i++) ops = {ops[21:0], ack_ops[i]};
  endtask

  int px[$];
  int py[$];

  initial begin
    logic [23:0] ops;
    int n, pi_, qsel, qx, qy, base;
    bit m, pinf_r, qinf_r, noisy;

    for (int x = 0; x < P; x++)
      for (int y = 0; y < P; y++)
        if (md(y * y) == md(x * x * x + A * x + 2)) begin
          px.push_back(x);
          py.push_back(y);
        end

    repeat (3) @(negedge clk);
    chk("rst_ctl", 32'({busy, done, r_inf, gfau_ack, gfau_op}), 0);
    chk("rst_x3", x3, 0);
    chk("rst_y3", y3, 0);
    chk("rst_prime", gfau_prime, 0);
    chk("rst_in0", gfau_in0, 0);
    chk("rst_in1", gfau_in1, 0);
    rst = 1'b0;

    spurious_en = 1'b1;
    dly_min = 0;
    dly_max = 20;

    op_check("dbl51", 1'b1, 5, 1, 1'b0, 0, 0, 1'b0, 1'b0, -1, ops);
    chk("dbl51_ops", 32'(ops), 32'(DBL_OPS));
    op_check("add51_63", 1'b0, 5, 1, 1'b0, 6, 3, 1'b0, 1'b0, -1, ops);
    chk("add51_63_x_lit", x3, 10);
    op_check("add106_51", 1'b0, 10, 6, 1'b0, 5, 1, 1'b0, 1'b0, -1, ops);
    chk("add106_51_x_lit", x3, 3);
    op_check("add_neg", 1'b0, 5, 1, 1'b0, 5, 16, 1'b0, 1'b0, 2, ops);
    op_check("add_pinf", 1'b0, 9, 9, 1'b1, 6, 3, 1'b0, 1'b0, 2, ops);
    op_check("add_qinf", 1'b0, 6, 3, 1'b0, 1, 1, 1'b1, 1'b0, 2, ops);
    op_check("add_promote", 1'b0, 5, 1, 1'b0, 5, 1, 1'b0, 1'b0, -1, ops);
    chk("add_promote_ops", 32'(ops), 32'(DBL_OPS));
    op_check("dbl_y0", 1'b1, 3, 0, 1'b0, 0, 0, 1'b0, 1'b0, 2, ops);
    op_check("dbl_noisy", 1'b1, 5, 1, 1'b0, 0, 0, 1'b0, 1'b1, -1, ops);

    for (int t = 0; t < 40; t++) begin
      m = $urandom_range(0, 1);
      pi_ = $urandom_range(0, px.size() - 1);
      qsel = $urandom_range(0, 3);
      if (qsel == 0) begin
        qx = px[pi_]; qy = py[pi_];
      end else if (qsel == 1) begin
        qx = px[pi_]; qy = md(-py[pi_]);
      end else begin
        n = $urandom_range(0, px.size() - 1);
        qx = px[n]; qy = py[n];
      end
      pinf_r = ($urandom_range(0, 7) == 0);
      qinf_r = ($urandom_range(0, 7) == 0);
      noisy = ($urandom_range(0, 3) == 0);
      op_check($sformatf("rnd%0d", t), m, px[pi_], py[pi_], pinf_r, qx, qy, qinf_r,
               noisy, -1, ops);
    end

    // Abort in the WAIT of step 5 (the divide) of a double
    spurious_en = 1'b0;
    dly_min = 5;
    dly_max = 5;
    base = ack_total;
    @(negedge clk);
    mode = 1'b1; x1 = 5; y1 = 1; p_inf = 1'b0; q_inf = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (ack_total - base < 5 && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    hold_done = 1'b1;
    chk("mid_reach", 32'(ack_total - base), 5);
    repeat (4) @(negedge clk);
    chk("mid_in0", gfau_in0, 9);
    chk("mid_in1", gfau_in1, 2);
    chk("mid_op", 32'(gfau_op), 3);
    chk("mid_busy", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ctl", 32'({busy, done, r_inf, gfau_ack, gfau_op}), 0);
    chk("mid_rst_in0", gfau_in0, 0);
    chk("mid_rst_in1", gfau_in1, 0);
    chk("mid_rst_prime", gfau_prime, 0);
    chk("mid_rst_xy", x3 | y3, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold_done = 1'b0;
    spurious_en = 1'b1;
    dly_min = 0;
    dly_max = 20;
    op_check("post_rst", 1'b1, 5, 1, 1'b0, 0, 0, 1'b0, 1'b0, -1, ops);
    chk("post_rst_ops", 32'(ops), 32'(DBL_OPS));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
